div32_iter: RTL

//   Multi-cycle RV32M divide/remainder unit; the inverse of the ALU's add/multiply datapath.

---
 rtl/div32_iter_pkg.sv | 8 +
 rtl/div32_iter_div_step.sv | 15 +
 rtl/div32_iter.sv | 87 ++++++++
 3 files changed

// File: rtl/div32_iter_pkg.sv
// div32_iter_pkg: op encodings and FSM states shared by the divider and its bench
package div32_iter_pkg;
    localparam logic [1:0] DIVOP_DIV  = 2'b00;
    localparam logic [1:0] DIVOP_DIVU = 2'b01;
    localparam logic [1:0] DIVOP_REM  = 2'b10;
    localparam logic [1:0] DIVOP_REMU = 2'b11;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/div32_iter_div_step.sv
// div_step: one restoring-division step (trial subtract, keep or restore)
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);
    logic [WIDTH:0] trial;
    assign trial = rem - {1'b0, divisor};
    // rem < 2*divisor, so a clear MSB means the trial stayed non-negative
    assign qbit = ~trial[WIDTH];
    assign rem_next = qbit ? trial[WIDTH-1:0] : rem[WIDTH-1:0];
endmodule

// File: rtl/div32_iter.sv
// div32_iter: multi-cycle RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring on magnitudes
module div32_iter
    import div32_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    state_t state;
    logic [CW-1:0] cnt;
    logic sel_rem, neg_q, neg_r, qbit, sgn;
    logic [WIDTH-1:0] rem, quo, dvs, nrem, mag_a, mag_b;
    assign sgn = (op == DIVOP_DIV) || (op == DIVOP_REM);
    assign mag_a = (sgn && srca[WIDTH-1]) ? -srca : srca;
    assign mag_b = (sgn && srcb[WIDTH-1]) ? -srcb : srcb;
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      ({rem, quo[WIDTH-1]}),
        .divisor  (dvs),
        .rem_next (nrem),
        .qbit     (qbit)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sel_rem     <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        sel_rem <= op[1];
                        neg_q   <= sgn && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        neg_r   <= sgn && srca[WIDTH-1];
                        rem     <= '0;
                        quo     <= mag_a;
                        dvs     <= mag_b;
                        cnt     <= CW'(WIDTH - 1);
                        // RISC-V divide by zero: all-ones quotient, untouched dividend as remainder
                        if (srcb == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            result      <= op[1] ? srca : '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem   <= nrem;
                    quo   <= {quo[WIDTH-2:0], qbit};
                    cnt   <= cnt - 1'b1;
                    state <= (cnt == '0) ? FIX : RUN;
                end
                default: begin
                    result      <= sel_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
                    div_by_zero <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
            endcase
        end
    end
endmodule
